pulse_stretcher_multi: RTL and testbench
========================================

// Module: pulse_stretcher_multi
// PURPOSE
//  Multi-channel synchronous pulse stretcher, next generation of the single-channel
//  stretcher: NUM_CH independent channels, run-time stretch length, level or rising-edge
//  trigger, optional retrigger and post-pulse holdoff, sticky missed-trigger flags.
//  Sits between raw strobes and slow indicators (LEDs, UART/status latching) in the tester.
// PARAMETERS
//  NUM_CH      4   number of independent channels
//  T_BITS      8   width of stretch length and per-channel timer
//  HOLDOFF     0   forced low cycles after each pulse (0 = none); must fit in T_BITS
//  EDGE_MODE   0   0: trigger on i_x level high; 1: trigger on i_x rising edge
// PORTS
//  i_clk      in   1              system clock, all logic on rising edge
//  i_rstn     in   1              reset, asynchronous assert, active-low
//  i_x        in   NUM_CH         trigger inputs, synchronous to i_clk
//  i_len      in   T_BITS         stretch length in cycles, shared, sampled per channel at trigger
//  i_retrig   in   1              1: trigger during STRETCH restarts timer with current i_len
//  i_ovr_clr  in   1              single-cycle clear of all o_ovr bits
//  o_y        out  NUM_CH         stretched outputs
//  o_busy     out  NUM_CH         channel in STRETCH or HOLDOFF
//  o_ovr      out  NUM_CH         sticky: a trigger was ignored
// BEHAVIOUR
//  - Reset (i_rstn=0): all channels ST_IDLE, timers 0, latched len 0, edge regs 0;
//    o_y=0, o_busy=0, o_ovr=0 immediately (async) and held until release.
//  - trig[c] = EDGE_MODE ? (i_x[c] & ~x_d[c]) : i_x[c]; x_d resets to 0, so an input
//    already high at reset release counts as one rising edge.
//  - States per channel: ST_IDLE, ST_STRETCH, ST_HOLDOFF. o_y[c] = (state==ST_STRETCH),
//    decoded from the state register (no combinational path i_x -> o_y).
//  - ST_IDLE: trig & i_len!=0 -> ST_STRETCH, len_q<=i_len, t<=0. trig & i_len==0 -> stay,
//    no o_ovr. o_y rises the cycle after trigger is sampled.
//  - ST_STRETCH: t increments each cycle; o_y high exactly len_q cycles. At t==len_q-1:
//    -> ST_HOLDOFF (t<=0) if HOLDOFF>0, else ST_IDLE. Retrigger (i_retrig & trig &
//    i_len!=0): t<=0, len_q<=i_len, stays ST_STRETCH; takes priority over terminal count.
//    trig with i_retrig=0: ignored, o_ovr[c]<=1.
//  - ST_HOLDOFF: o_y=0 for exactly HOLDOFF cycles, then ST_IDLE; any trig -> o_ovr[c]<=1.
//  - Back-to-back level mode, HOLDOFF=0, i_x held high: o_y high len_q, low 1 cycle
//    (ST_IDLE), high again; period len_q+1.
//  - i_len change mid-pulse has no effect unless retriggered.
//  - o_ovr: set wins over i_ovr_clr in the same cycle; otherwise i_ovr_clr clears all bits.
//  - Timer never wraps: max t = 2^T_BITS-2; len_q = 2^T_BITS-1 is the longest pulse.
//  - Channels fully independent; simultaneous triggers on all channels all accepted.
//  - Invalid state encodings recover to ST_IDLE next cycle (safe default branch).
// STRUCTURE
//  - Package pulse_stretcher_pkg: typedef enum logic [1:0] t_stretch_state
//    {ST_IDLE, ST_STRETCH, ST_HOLDOFF}; helper localparam for invalid-encoding default.
//  - Sub-module pulse_stretcher_chan: one channel (edge reg, FSM, timer, len_q, ovr bit),
//    parameters T_BITS/HOLDOFF/EDGE_MODE; top is a generate loop of NUM_CH instances
//    plus shared i_len/i_retrig/i_ovr_clr fan-out.
// TESTING
//  1 Level mode, i_len=5, 1-cycle pulse on i_x[0] -> o_y[0] high exactly 5 cycles starting
//    1 cycle later; other channels stay 0; o_ovr=0.
//  2 i_retrig=1, i_len=10, retrigger at 6th high cycle -> o_y[0] high 15 cycles total;
//    repeat with i_retrig=0 -> 10 cycles, o_ovr[0]=1 until i_ovr_clr.
//  3 HOLDOFF=3, i_len=4, i_x held high -> pattern 4 high / 4 low (3 holdoff + 1 idle);
//    o_ovr set by triggers during holdoff; i_ovr_clr and new miss same cycle -> o_ovr stays 1.
//  4 EDGE_MODE=1, i_x held high 50 cycles, i_len=8 -> single 8-cycle pulse; i_x high at
//    reset release -> one pulse after release.
//  5 i_len=0 trigger -> no pulse, no ovr; i_len=255 (T_BITS=8) -> 255-cycle pulse, no wrap.
//  6 Assert i_rstn=0 mid-pulse (between clocks) -> o_y/o_busy/o_ovr drop to 0
//    asynchronously; after release all 4 channels triggered together -> identical pulses.

Source files
------------

// File: rtl/pulse_stretcher_pkg.sv
// Shared types and helpers for the multi-channel pulse stretcher.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_HOLDOFF = 2'd2
  } t_stretch_state;

  // Landing state for any unused encoding (2'd3).
  localparam t_stretch_state ST_SAFE = ST_IDLE;

  function automatic logic f_trig(input logic x, input logic x_prev, input logic edge_mode);
    logic r;
    if (edge_mode) begin
      r = x & ~x_prev;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/pulse_stretcher_chan.sv
// One stretcher channel: trigger detect, IDLE/STRETCH/HOLDOFF FSM, cycle timer,
// latched length and sticky missed-trigger flag.
module pulse_stretcher_chan
  import pulse_stretcher_pkg::*;
#(
  parameter int T_BITS    = 8,
  parameter int HOLDOFF   = 0,
  parameter int EDGE_MODE = 0
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_x,
  input  logic [T_BITS-1:0] i_len,
  input  logic              i_retrig,
  input  logic              i_ovr_clr,
  output logic              o_y,
  output logic              o_busy,
  output logic              o_ovr
);

  localparam logic [T_BITS-1:0] ZERO    = {T_BITS{1'b0}};
  localparam logic [T_BITS-1:0] ONE     = T_BITS'(1);
  localparam logic [T_BITS-1:0] HO_LAST = T_BITS'(HOLDOFF - 1);

  t_stretch_state    state_q, state_d;
  logic [T_BITS-1:0] t_q, t_d;
  logic [T_BITS-1:0] len_q, len_d;
  logic              x_q;
  logic              y_q, y_d;
  logic              busy_q, busy_d;
  logic              ovr_q, ovr_d;
  logic              trig_s, len_ok_s, miss_s;

  // State register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      t_q     <= ZERO;
      len_q   <= ZERO;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      len_q   <= len_d;
      x_q     <= i_x;
      y_q     <= y_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state logic; a retrigger outranks the terminal count
  always_comb begin
    trig_s   = f_trig(i_x, x_q, EDGE_MODE != 0);
    len_ok_s = (i_len != ZERO);
    state_d  = state_q;
    t_d      = t_q;
    len_d    = len_q;
    miss_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig_s && len_ok_s) begin
          state_d = ST_STRETCH;
          t_d     = ZERO;
          len_d   = i_len;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STRETCH: begin
        if (trig_s && i_retrig && len_ok_s) begin
          t_d   = ZERO;
          len_d = i_len;
        end else if (t_q == len_q - ONE) begin
          miss_s  = trig_s;
          state_d = (HOLDOFF > 0) ? ST_HOLDOFF : ST_IDLE;
          t_d     = ZERO;
        end else begin
          miss_s = trig_s;
          t_d    = t_q + ONE;
        end
      end
      ST_HOLDOFF: begin
        miss_s = trig_s;
        if (t_q == HO_LAST) begin
          state_d = ST_IDLE;
          t_d     = ZERO;
        end else begin
          t_d = t_q + ONE;
        end
      end
      default: begin
        state_d = ST_SAFE;
        t_d     = ZERO;
        len_d   = ZERO;
      end
    endcase
  end

  // Output decode; a miss in the same cycle beats the clear
  always_comb begin
    y_d    = (state_d == ST_STRETCH);
    busy_d = (state_d == ST_STRETCH) || (state_d == ST_HOLDOFF);
    if (miss_s) begin
      ovr_d = 1'b1;
    end else if (i_ovr_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  assign o_y    = y_q;
  assign o_busy = busy_q;
  assign o_ovr  = ovr_q;

endmodule

// File: rtl/pulse_stretcher_multi.sv
// NUM_CH independent pulse stretchers sharing length, retrigger and overrun-clear controls.
module pulse_stretcher_multi
  import pulse_stretcher_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int T_BITS    = 8,
  parameter int HOLDOFF   = 0,
  parameter int EDGE_MODE = 0
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [NUM_CH-1:0] i_x,
  input  logic [T_BITS-1:0] i_len,
  input  logic              i_retrig,
  input  logic              i_ovr_clr,
  output logic [NUM_CH-1:0] o_y,
  output logic [NUM_CH-1:0] o_busy,
  output logic [NUM_CH-1:0] o_ovr
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pulse_stretcher_chan #(
      .T_BITS   (T_BITS),
      .HOLDOFF  (HOLDOFF),
      .EDGE_MODE(EDGE_MODE)
    ) u_chan (
      .i_clk    (i_clk),
      .i_rstn   (i_rstn),
      .i_x      (i_x[c]),
      .i_len    (i_len),
      .i_retrig (i_retrig),
      .i_ovr_clr(i_ovr_clr),
      .o_y      (o_y[c]),
      .o_busy   (o_busy[c]),
      .o_ovr    (o_ovr[c])
    );
  end

endmodule

// File: tb/tb_pulse_stretcher_multi.sv
// Scoreboard bench: stimulus queues expected pulses (dut, channel, start cycle, length);
// a negedge monitor measures every completed pulse on all three configurations and pops/compares.
module tb_pulse_stretcher_multi;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] x_l, x_h, x_e;
  logic [7:0] len;
  logic       retrig, ovr_clr;
  logic [3:0] y_l, busy_l, ovr_l;
  logic [3:0] y_h, busy_h, ovr_h;
  logic [3:0] y_e, busy_e, ovr_e;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int dut;
    int ch;
    int start;
    int len;
  } pulse_t;
  pulse_t exp_q[$];

  int run_len   [3][4];
  int run_start [3][4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pulse_stretcher_multi #(.NUM_CH(4), .T_BITS(8), .HOLDOFF(0), .EDGE_MODE(0)) dut_l (
    .i_clk(clk), .i_rstn(rstn), .i_x(x_l), .i_len(len), .i_retrig(retrig),
    .i_ovr_clr(ovr_clr), .o_y(y_l), .o_busy(busy_l), .o_ovr(ovr_l));

  pulse_stretcher_multi #(.NUM_CH(4), .T_BITS(8), .HOLDOFF(3), .EDGE_MODE(0)) dut_h (
    .i_clk(clk), .i_rstn(rstn), .i_x(x_h), .i_len(len), .i_retrig(retrig),
    .i_ovr_clr(ovr_clr), .o_y(y_h), .o_busy(busy_h), .o_ovr(ovr_h));

  pulse_stretcher_multi #(.NUM_CH(4), .T_BITS(8), .HOLDOFF(0), .EDGE_MODE(1)) dut_e (
    .i_clk(clk), .i_rstn(rstn), .i_x(x_e), .i_len(len), .i_retrig(retrig),
    .i_ovr_clr(ovr_clr), .o_y(y_e), .o_busy(busy_e), .o_ovr(ovr_e));

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int d, input int c, input int s, input int l);
    pulse_t e;
    e.dut = d; e.ch = c; e.start = s; e.len = l;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic score(input int d, input int c, input int s, input int l);
    int idx;
    pulse_t e;
    idx = -1;
    foreach (exp_q[i]) begin
      if (idx < 0 && exp_q[i].dut == d && exp_q[i].ch == c) idx = i;
    end
    checks++;
    if (idx < 0) begin
      failures++;
      $display("FAIL stray_pulse dut=%0d ch=%0d got start=%0d len=%0d expected no pulse", d, c, s, l);
    end else begin
      e = exp_q[idx];
      exp_q.delete(idx);
      if (e.start != s || e.len != l) begin
        failures++;
        $display("FAIL pulse dut=%0d ch=%0d got start=%0d len=%0d expected start=%0d len=%0d",
                 d, c, s, l, e.start, e.len);
      end
    end
  endtask

  // Monitor: measure each pulse on the registered outputs; a pulse cut by reset is dropped.
  initial begin
    logic [3:0] yv;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        yv = (d == 0) ? y_l : (d == 1) ? y_h : y_e;
        for (int c = 0; c < 4; c++) begin
          if (!rstn) begin
            run_len[d][c] = 0;
          end else if (yv[c]) begin
            if (run_len[d][c] == 0) run_start[d][c] = cyc;
            run_len[d][c] = run_len[d][c] + 1;
          end else if (run_len[d][c] != 0) begin
            score(d, c, run_start[d][c], run_len[d][c]);
            run_len[d][c] = 0;
          end
        end
      end
    end
  end

  initial begin
    int t0;
    rstn = 1'b0; x_l = 4'd0; x_h = 4'd0; x_e = 4'd0;
    len = 8'd0; retrig = 1'b0; ovr_clr = 1'b0;
    step(3);
    chk("reset_l", {20'd0, y_l, busy_l, ovr_l}, 32'd0);
    chk("reset_h", {20'd0, y_h, busy_h, ovr_h}, 32'd0);
    chk("reset_e", {20'd0, y_e, busy_e, ovr_e}, 32'd0);
    rstn = 1'b1;
    step(2);

    // 1: single-cycle trigger, len 5
    len = 8'd5; t0 = cyc; x_l = 4'b0001; push(0, 0, t0 + 1, 5);
    step(1); x_l = 4'd0;
    step(2);
    chk("t1_y_mid", {28'd0, y_l}, 32'h1);
    chk("t1_busy_mid", {28'd0, busy_l}, 32'h1);
    step(6);
    chk("t1_y_after", {28'd0, y_l}, 32'h0);
    chk("t1_ovr", {28'd0, ovr_l}, 32'h0);

    // 2a: retrigger taking effect on the 6th high cycle -> 5 + 10
    len = 8'd10; retrig = 1'b1; t0 = cyc; x_l = 4'b0001; push(0, 0, t0 + 1, 15);
    step(1); x_l = 4'd0;
    step(4); x_l = 4'b0001;
    step(1); x_l = 4'd0;
    step(14);
    chk("t2a_ovr", {28'd0, ovr_l}, 32'h0);

    // 2b: same timing, retrigger disabled -> 10 cycles, miss flagged
    retrig = 1'b0; t0 = cyc; x_l = 4'b0001; push(0, 0, t0 + 1, 10);
    step(1); x_l = 4'd0;
    step(4); x_l = 4'b0001;
    step(1); x_l = 4'd0;
    step(10);
    chk("t2b_ovr_set", {28'd0, ovr_l}, 32'h1);
    step(5);
    chk("t2b_ovr_sticky", {28'd0, ovr_l}, 32'h1);
    ovr_clr = 1'b1; step(1); ovr_clr = 1'b0;
    chk("t2b_ovr_clr", {28'd0, ovr_l}, 32'h0);

    // 3: holdoff 3, level held high -> 4 high / 4 low
    len = 8'd4; t0 = cyc; x_h = 4'b0001;
    push(1, 0, t0 + 1, 4); push(1, 0, t0 + 9, 4); push(1, 0, t0 + 17, 4);
    step(20); x_h = 4'd0;
    chk("t3_ovr_held", {28'd0, ovr_h}, 32'h1);
    step(6);
    ovr_clr = 1'b1; step(1); ovr_clr = 1'b0;
    chk("t3_ovr_clr", {28'd0, ovr_h}, 32'h0);

    t0 = cyc; x_h = 4'b0010; push(1, 1, t0 + 1, 4);
    step(1); x_h = 4'd0;
    step(4);
    chk("t3_busy_holdoff", {24'd0, busy_h, y_h}, 32'h20);
    chk("t3_ovr_pre", {28'd0, ovr_h}, 32'h0);
    x_h = 4'b0010; step(1); x_h = 4'd0;
    chk("t3_ovr_holdoff_miss", {28'd0, ovr_h}, 32'h2);
    step(3);
    chk("t3_busy_idle", {28'd0, busy_h}, 32'h0);

    t0 = cyc; x_h = 4'b0010; push(1, 1, t0 + 1, 4);
    step(1); x_h = 4'd0;
    step(4);
    x_h = 4'b0010; ovr_clr = 1'b1;
    step(1); x_h = 4'd0; ovr_clr = 1'b0;
    chk("t3_set_beats_clr", {28'd0, ovr_h}, 32'h2);
    step(4);
    ovr_clr = 1'b1; step(1); ovr_clr = 1'b0;
    chk("t3_ovr_clr2", {28'd0, ovr_h}, 32'h0);

    // 4: edge mode, input held high 50 cycles -> one 8-cycle pulse
    len = 8'd8; t0 = cyc; x_e = 4'b0001; push(2, 0, t0 + 1, 8);
    step(50); x_e = 4'd0;
    step(2);
    chk("t4_ovr", {28'd0, ovr_e}, 32'h0);
    chk("t4_busy", {28'd0, busy_e}, 32'h0);

    // 5: zero length ignored silently; maximum length does not wrap
    len = 8'd0; x_l = 4'b1000;
    step(1); x_l = 4'd0;
    chk("t5_len0_busy", {24'd0, y_l, busy_l}, 32'h0);
    step(2);
    chk("t5_len0_ovr", {28'd0, ovr_l}, 32'h0);
    len = 8'd255; t0 = cyc; x_l = 4'b0001; push(0, 0, t0 + 1, 255);
    step(1); x_l = 4'd0;
    step(256);
    chk("t5_len255_done", {24'd0, y_l, busy_l}, 32'h0);

    // 6: asynchronous reset mid-pulse, then all channels together
    len = 8'd12; x_l = 4'b0001;
    step(1); x_l = 4'd0;
    step(2); x_l = 4'b0001;
    step(1); x_l = 4'd0;
    step(1);
    chk("t6_pre_rst", {24'd0, y_l, ovr_l}, 32'h11);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    chk("t6_async_rst", {20'd0, y_l, busy_l, ovr_l}, 32'd0);
    x_e = 4'b0100;
    step(2);
    chk("t6_rst_held_l", {20'd0, y_l, busy_l, ovr_l}, 32'd0);
    chk("t6_rst_held_e", {20'd0, y_e, busy_e, ovr_e}, 32'd0);
    len = 8'd6; t0 = cyc; rstn = 1'b1; x_l = 4'b1111;
    for (int c = 0; c < 4; c++) push(0, c, t0 + 1, 6);
    push(2, 2, t0 + 1, 6);
    step(1); x_l = 4'd0;
    step(3);
    chk("t6_all_high", {28'd0, y_l}, 32'hf);
    step(6);
    x_e = 4'd0;
    step(2);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_pulses got=%0d pending expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
